// File: rtl/dct_inv_stream_if.sv
// Coefficient-in / sample-out streaming bus for the 4-point inverse DCT engine.
interface dct_inv_stream_if #(
   parameter int unsigned CW = 10,
   parameter int unsigned SW = 13
);
   logic signed [CW-1:0] coef_i;
   logic                 coef_valid_i;
   logic                 coef_ready_o;
   logic signed [SW-1:0] smp_o;
   logic                 smp_valid_o;
   logic                 smp_ready_i;
   logic                 smp_last_o;
   logic                 smp_sat_o;

   // Source of coefficients and sink of samples
   modport master (
      output coef_i, coef_valid_i, smp_ready_i,
      input  coef_ready_o, smp_o, smp_valid_o, smp_last_o, smp_sat_o
   );

   // The inverse DCT engine itself
   modport slave (
      input  coef_i, coef_valid_i, smp_ready_i,
      output coef_ready_o, smp_o, smp_valid_o, smp_last_o, smp_sat_o
   );
endinterface

// File: rtl/dct_inv_stream.sv
// Streaming 4-point integer inverse DCT: loads X0..X3 serially, computes the
// 20x-scaled block in one cycle, then emits y0..y3 serially with saturation flags.
module dct_inv_stream #(
   parameter int unsigned CW = 10,
   parameter int unsigned SW = 13
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   dct_inv_stream_if.slave bus
);

   localparam int unsigned IW = 15;
   localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (SW - 1)) - 1);
   localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_CALC = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t               r_state;
   logic [1:0]           r_cnt;
   logic [1:0]           r_idx;
   logic signed [CW-1:0] r_x [4];
   logic signed [SW-1:0] r_y [4];
   logic [3:0]           r_sat;
   logic signed [SW-1:0] r_smp;
   logic                 r_smp_valid;
   logic                 r_smp_last;
   logic                 r_smp_sat;
   logic                 r_coef_ready;

   logic signed [IW-1:0] w_x [4];
   logic signed [IW-1:0] w_5x0, w_5x2;
   logic signed [IW-1:0] w_4x1, w_2x1, w_4x3, w_2x3;
   logic signed [IW-1:0] w_sum [4];
   logic signed [SW-1:0] w_y [4];
   logic [3:0]           w_sat;
   logic [1:0]           w_nidx;

   // Sign-extend the stored coefficients to the intermediate width
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_x[k] = {{(IW-CW){r_x[k][CW-1]}}, r_x[k]};
      end
   end

   // Shift-and-add partial products; no multipliers needed
   assign w_5x0 = (w_x[0] <<< 2) + w_x[0];
   assign w_5x2 = (w_x[2] <<< 2) + w_x[2];
   assign w_4x1 = w_x[1] <<< 2;
   assign w_2x1 = w_x[1] <<< 1;
   assign w_4x3 = w_x[3] <<< 2;
   assign w_2x3 = w_x[3] <<< 1;

   // Weighted inverse butterfly (row weights 5,2,5,2 fold the 20x scale in)
   assign w_sum[0] = w_5x0 + w_4x1 + w_5x2 + w_2x3;
   assign w_sum[1] = w_5x0 + w_2x1 - w_5x2 - w_4x3;
   assign w_sum[2] = w_5x0 - w_2x1 - w_5x2 + w_4x3;
   assign w_sum[3] = w_5x0 - w_4x1 + w_5x2 - w_2x3;

   // Clamp each sum to the output range and flag when the clamp engaged
   always_comb begin
      w_sat = '0;
      for (int k = 0; k < 4; k++) begin
         w_y[k] = SW'(w_sum[k]);
         if (w_sum[k] > SAT_MAX) begin
            w_y[k]   = SW'(SAT_MAX);
            w_sat[k] = 1'b1;
         end else if (w_sum[k] < SAT_MIN) begin
            w_y[k]   = SW'(SAT_MIN);
            w_sat[k] = 1'b1;
         end
      end
   end

   assign w_nidx = r_idx + 2'd1;

   // Block FSM: collect coefficients, compute once, stream samples out
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= S_LOAD;
         r_cnt        <= 2'd0;
         r_idx        <= 2'd0;
         r_sat        <= '0;
         r_smp        <= '0;
         r_smp_valid  <= 1'b0;
         r_smp_last   <= 1'b0;
         r_smp_sat    <= 1'b0;
         r_coef_ready <= 1'b1;
         for (int k = 0; k < 4; k++) begin
            r_x[k] <= '0;
            r_y[k] <= '0;
         end
      end else begin
         case (r_state)
            S_LOAD: begin
               if (bus.coef_valid_i && r_coef_ready) begin
                  r_x[r_cnt] <= bus.coef_i;
                  r_cnt      <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_state      <= S_CALC;
                     r_coef_ready <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               for (int k = 0; k < 4; k++) begin
                  r_y[k] <= w_y[k];
               end
               r_sat       <= w_sat;
               r_smp       <= w_y[0];
               r_smp_sat   <= w_sat[0];
               r_smp_last  <= 1'b0;
               r_smp_valid <= 1'b1;
               r_idx       <= 2'd0;
               r_state     <= S_SEND;
            end
            S_SEND: begin
               if (r_smp_valid && bus.smp_ready_i) begin
                  if (r_idx == 2'd3) begin
                     // Last sample leaves: reopen the input on the same edge
                     r_state      <= S_LOAD;
                     r_cnt        <= 2'd0;
                     r_idx        <= 2'd0;
                     r_smp        <= '0;
                     r_smp_valid  <= 1'b0;
                     r_smp_last   <= 1'b0;
                     r_smp_sat    <= 1'b0;
                     r_coef_ready <= 1'b1;
                  end else begin
                     r_idx      <= w_nidx;
                     r_smp      <= r_y[w_nidx];
                     r_smp_sat  <= r_sat[w_nidx];
                     r_smp_last <= (w_nidx == 2'd3);
                  end
               end
            end
            default: begin
               r_state      <= S_LOAD;
               r_cnt        <= 2'd0;
               r_idx        <= 2'd0;
               r_smp_valid  <= 1'b0;
               r_coef_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.coef_ready_o = r_coef_ready;
   assign bus.smp_o        = r_smp;
   assign bus.smp_valid_o  = r_smp_valid;
   assign bus.smp_last_o   = r_smp_last;
   assign bus.smp_sat_o    = r_smp_sat;

endmodule

// File: tb/tb_dct_inv_stream.sv
// Directed bench for dct_inv_stream with a sample scoreboard.
module tb_dct_inv_stream;

   localparam int unsigned CW = 10;
   localparam int unsigned SW = 13;

   typedef struct {
      logic signed [SW-1:0] smp;
      logic                 last;
      logic                 sat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   last_cyc = 0;
   exp_t sb [$];

   dct_inv_stream_if #(.CW(CW), .SW(SW)) bus ();

   dct_inv_stream #(.CW(CW), .SW(SW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: a transfer seen at the falling edge completes at the next rising edge
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.smp_valid_o && bus.smp_ready_i) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow obs=%0d exp=no_sample", bus.smp_o);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (bus.smp_o === e.smp && bus.smp_last_o === e.last && bus.smp_sat_o === e.sat)
            else begin
               errors++;
               $error("FAIL sample obs=%0d/last%0b/sat%0b exp=%0d/last%0b/sat%0b",
                      bus.smp_o, bus.smp_last_o, bus.smp_sat_o, e.smp, e.last, e.sat);
            end
         end
         if (bus.smp_last_o) last_cyc = cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic push1(input int y, input bit last, input bit sat);
      exp_t e;
      e.smp  = SW'(y);
      e.last = last;
      e.sat  = sat;
      sb.push_back(e);
   endtask

   task automatic push_block(input int y0, input int y1, input int y2, input int y3, input bit [3:0] sat);
      push1(y0, 1'b0, sat[0]);
      push1(y1, 1'b0, sat[1]);
      push1(y2, 1'b0, sat[2]);
      push1(y3, 1'b1, sat[3]);
   endtask

   // Reference model: weighted inverse matrix applied with plain multiplies, then clamped
   task automatic push_model(input int c0, input int c1, input int c2, input int c3);
      int w [4][4];
      int c [4];
      int y;
      w = '{'{5, 4, 5, 2}, '{5, 2, -5, -4}, '{5, -2, -5, 4}, '{5, -4, 5, -2}};
      c = '{c0, c1, c2, c3};
      for (int r = 0; r < 4; r++) begin
         y = 0;
         for (int j = 0; j < 4; j++) y += w[r][j] * c[j];
         if (y > 4095)       push1(4095,  r == 3, 1'b1);
         else if (y < -4096) push1(-4096, r == 3, 1'b1);
         else                push1(y,     r == 3, 1'b0);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that took the coefficient
   task automatic send_coef(input int c);
      int n = 0;
      bus.coef_i       = CW'(c);
      bus.coef_valid_i = 1'b1;
      @(negedge clk);
      while (!bus.coef_ready_o && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $error("FAIL coef_timeout obs=ready_low exp=ready_high");
      end
      @(posedge clk);
      #1;
      bus.coef_valid_i = 1'b0;
   endtask

   task automatic send_block(input int c0, input int c1, input int c2, input int c3);
      send_coef(c0);
      send_coef(c1);
      send_coef(c2);
      send_coef(c3);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || bus.smp_valid_o) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $error("FAIL drain_timeout obs=%0d_pending exp=0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c_start;
      int n;
      rst_n            = 1'b0;
      bus.coef_i       = '0;
      bus.coef_valid_i = 1'b0;
      bus.smp_ready_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.smp_valid_o, 0);
      chk("rst_smp",   bus.smp_o,       0);
      chk("rst_last",  bus.smp_last_o,  0);
      chk("rst_sat",   bus.smp_sat_o,   0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", bus.coef_ready_o, 1);

      // Basic block with latency checks
      push_block(100, 200, 400, 0, 4'b0000);
      send_block(35, 0, -25, 25);
      chk("calc_valid", bus.smp_valid_o,  0);
      chk("calc_ready", bus.coef_ready_o, 0);
      @(posedge clk);
      #1;
      chk("first_valid", bus.smp_valid_o, 1);
      chk("first_smp",   bus.smp_o,       100);
      wait_drain();
      chk("idle_ready", bus.coef_ready_o, 1);

      // Second directed block
      push_block(780, 1660, 1600, 120, 4'b0000);
      send_block(208, 69, -118, 27);
      wait_drain();

      // Sink stall while y1 is presented
      c_start = cyc;
      push_block(100, 200, 400, 0, 4'b0000);
      send_block(35, 0, -25, 25);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.smp_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_smp",   bus.smp_o,       200);
         chk("stall_valid", bus.smp_valid_o, 1);
         chk("stall_last",  bus.smp_last_o,  0);
         @(posedge clk);
         #1;
      end
      bus.smp_ready_i = 1'b1;
      wait_drain();
      chk("stall_block_cycles", last_cyc - c_start, 12);

      // Positive and negative saturation
      push_block(4095, -1022, 1022, 2044, 4'b0001);
      send_block(511, 511, 511, 511);
      wait_drain();
      push_block(-4096, 1024, -1024, -2048, 4'b0001);
      send_block(-512, -512, -512, -512);
      wait_drain();

      // Reset after a partial block
      send_coef(11);
      send_coef(-7);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("partial_rst_ready", bus.coef_ready_o, 1);
      push_block(100, 200, 400, 0, 4'b0000);
      send_block(35, 0, -25, 25);
      wait_drain();

      // Reset in the middle of SEND drops valid without waiting for a clock edge
      push_block(780, 1660, 1600, 120, 4'b0000);
      send_block(208, 69, -118, 27);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midsend_valid", bus.smp_valid_o, 0);
      chk("midsend_smp",   bus.smp_o,       0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midsend_ready", bus.coef_ready_o, 1);

      // Back-to-back blocks with junk offered while the engine is busy
      push_block(780, 1660, 1600, 120, 4'b0000);
      send_block(208, 69, -118, 27);
      bus.coef_i       = CW'(-300);
      bus.coef_valid_i = 1'b1;
      n = 0;
      while (!bus.coef_ready_o && n < 50) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("busy_cycles", n, 5);
      begin
         int a0, a1, a2, a3;
         a0 = int'($urandom_range(0, 1023)) - 512;
         a1 = int'($urandom_range(0, 1023)) - 512;
         a2 = int'($urandom_range(0, 1023)) - 512;
         a3 = int'($urandom_range(0, 1023)) - 512;
         push_model(a0, a1, a2, a3);
         send_block(a0, a1, a2, a3);
      end
      wait_drain();

      // A few more model-checked blocks with a throttled sink
      for (int b = 0; b < 3; b++) begin
         int a0, a1, a2, a3;
         a0 = int'($urandom_range(0, 1023)) - 512;
         a1 = int'($urandom_range(0, 1023)) - 512;
         a2 = int'($urandom_range(0, 1023)) - 512;
         a3 = int'($urandom_range(0, 1023)) - 512;
         push_model(a0, a1, a2, a3);
         send_block(a0, a1, a2, a3);
         bus.smp_ready_i = 1'b0;
         @(posedge clk);
         #1;
         @(posedge clk);
         #1;
         bus.smp_ready_i = 1'b1;
         wait_drain();
      end
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
